// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes halt the FSM and raise o_illegal.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

  localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] DST_RT = 2'b00;
  localparam logic [SEL_W-1:0] DST_RD = 2'b01;
  localparam logic [SEL_W-1:0] DST_RA = 2'b10;

  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

  localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PCS_RS     = 2'b11;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_UNUSED    = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  state_t r_state;
  state_t w_next_state;
  state_t w_decode_state;
  logic   w_is_illegal;

  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic             w_iord;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_write;
  logic [SEL_W-1:0] w_reg_dst;
  logic [SEL_W-1:0] w_mem_to_reg;
  logic             w_alu_src_a;
  logic [SEL_W-1:0] w_alu_src_b;
  logic [SEL_W-1:0] w_pc_source;
  logic             w_instr_done;

  // State register; reset is synchronous and always lands in FETCH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcode dispatch used by DECODE.
  always_comb begin
    w_decode_state = S_FETCH;
    w_is_illegal   = 1'b0;
    case (i_opcode)
      OP_LW, OP_SW:   w_decode_state = S_MEM_ADDR;
      OP_RTYPE:       w_decode_state = (i_funct == FN_JR) ? S_JR : S_R_EXEC;
      OP_BEQ, OP_BNE: w_decode_state = S_BRANCH;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:
                      w_decode_state = S_I_EXEC;
      OP_J:           w_decode_state = S_JUMP;
      OP_JAL:         w_decode_state = S_JAL;
      default:        w_is_illegal   = 1'b1;
    endcase
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next_state    = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = DST_RT;
    w_mem_to_reg    = WB_ALUOUT;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_REG;
    w_pc_source     = PCS_ALU;
    w_instr_done    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (i_mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        if (w_is_illegal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          w_next_state = S_HALT;
`else
          w_instr_done = 1'b1;
          w_next_state = S_FETCH;
`endif
        end else begin
          w_next_state = w_decode_state;
        end
      end
      S_MEM_ADDR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (i_mem_ready) begin
          w_next_state = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = DST_RT;
        w_mem_to_reg = WB_MDR;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (i_mem_ready) begin
          w_instr_done = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_R_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_REG;
        w_next_state = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = DST_RD;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCS_ALUOUT;
        w_instr_done    = 1'b1;
        w_next_state    = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCS_JUMP;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_I_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = DST_RT;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCS_JUMP;
        w_reg_write  = 1'b1;
        w_reg_dst    = DST_RA;
        w_mem_to_reg = WB_PC;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JR: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCS_RS;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        w_next_state = S_HALT;
      end
`endif
      // Unreachable encodings recover to FETCH.
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Strobes and requests are suppressed in any cycle where reset is asserted.
  assign o_pc_write      = w_pc_write      & i_rst_n;
  assign o_pc_write_cond = w_pc_write_cond & i_rst_n;
  assign o_mem_read      = w_mem_read      & i_rst_n;
  assign o_mem_write     = w_mem_write     & i_rst_n;
  assign o_ir_write      = w_ir_write      & i_rst_n;
  assign o_reg_write     = w_reg_write     & i_rst_n;
  assign o_instr_done    = w_instr_done    & i_rst_n;

  assign o_iord       = w_iord;
  assign o_reg_dst    = w_reg_dst;
  assign o_mem_to_reg = w_mem_to_reg;
  assign o_alu_src_a  = w_alu_src_a;
  assign o_alu_src_b  = w_alu_src_b;
  assign o_pc_source  = w_pc_source;
  assign o_state      = r_state;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign o_illegal = (r_state == S_HALT);
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one table row per clock cycle, plus reset corner cases.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, instr_done, illegal;
  logic [3:0] state;

  multicycle_control dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_opcode       (opcode),
    .i_funct        (funct),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_pc_write_cond(pc_write_cond),
    .o_iord         (iord),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_ir_write     (ir_write),
    .o_reg_write    (reg_write),
    .o_reg_dst      (reg_dst),
    .o_mem_to_reg   (mem_to_reg),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_pc_source    (pc_source),
    .o_instr_done   (instr_done),
    .o_state        (state),
    .o_illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {state, pw, pwc, iord, mr, mw, irw, rw, reg_dst, mem_to_reg, src_a, src_b, pc_src, done, illegal}
  logic [21:0] act;
  assign act = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, instr_done, illegal};

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Strobe groups, bit order {pw, pwc, iord, mr, mw, irw, rw}
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FRDY  = 7'b1001010;
  localparam logic [6:0] SB_FWAIT = 7'b0001000;
  localparam logic [6:0] SB_MRD   = 7'b0011000;
  localparam logic [6:0] SB_MWR   = 7'b0010100;
  localparam logic [6:0] SB_RW    = 7'b0000001;
  localparam logic [6:0] SB_BR    = 7'b0100000;
  localparam logic [6:0] SB_PC    = 7'b1000000;
  localparam logic [6:0] SB_JAL   = 7'b1000001;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, JAL = 6'b000011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  function automatic logic [21:0] ev(input logic [3:0] st, input logic [6:0] sb,
                                     input logic [1:0] rd, input logic [1:0] m2r,
                                     input logic a, input logic [1:0] b, input logic [1:0] ps,
                                     input logic dn, input logic ill);
    return {st, sb, rd, m2r, a, b, ps, dn, ill};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [21:0] e);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
    end
  endtask

  task automatic fetch_decode_rows(input logic [5:0] op, input logic [5:0] fn);
    add(1, op, fn, 1, ev(4'd0, SB_FRDY, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
    add(1, op, fn, 0, ev(4'd1, SB_NONE, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;

    // Reset held: strobes gated, FETCH selects still visible
    add(0, RT, 0, 1, ev(4'd0, SB_NONE, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
    add(0, RT, 0, 1, ev(4'd0, SB_NONE, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
    // LW, no waits: 0,1,2,3,4
    fetch_decode_rows(LW, 0);
    add(1, LW, 0, 1, ev(4'd2, SB_NONE, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0));
    add(1, LW, 0, 1, ev(4'd3, SB_MRD,  2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add(1, LW, 0, 1, ev(4'd4, SB_RW,   2'b00, 2'b01, 0, 2'b00, 2'b00, 1, 0));
    // SW with 3 wait cycles in MEM_WRITE
    fetch_decode_rows(SW, 0);
    add(1, SW, 0, 0, ev(4'd2, SB_NONE, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0));
    add(1, SW, 0, 0, ev(4'd5, SB_MWR,  2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add(1, SW, 0, 0, ev(4'd5, SB_MWR,  2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add(1, SW, 0, 0, ev(4'd5, SB_MWR,  2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    add(1, SW, 0, 1, ev(4'd5, SB_MWR,  2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0));
    // ADD with one FETCH wait; ready low elsewhere is ignored
    add(1, RT, F_ADD, 0, ev(4'd0, SB_FWAIT, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
    fetch_decode_rows(RT, F_ADD);
    add(1, RT, F_ADD, 0, ev(4'd6, SB_NONE, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0));
    add(1, RT, F_ADD, 0, ev(4'd7, SB_RW,   2'b01, 2'b00, 0, 2'b00, 2'b00, 1, 0));
    // JR
    fetch_decode_rows(RT, F_JR);
    add(1, RT, F_JR, 1, ev(4'd13, SB_PC, 2'b00, 2'b00, 0, 2'b00, 2'b11, 1, 0));
    // JAL
    fetch_decode_rows(JAL, 0);
    add(1, JAL, 0, 1, ev(4'd12, SB_JAL, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    // BEQ, BNE
    fetch_decode_rows(BEQ, 0);
    add(1, BEQ, 0, 1, ev(4'd8, SB_BR, 2'b00, 2'b00, 1, 2'b00, 2'b01, 1, 0));
    fetch_decode_rows(BNE, 0);
    add(1, BNE, 0, 0, ev(4'd8, SB_BR, 2'b00, 2'b00, 1, 2'b00, 2'b01, 1, 0));
    // J
    fetch_decode_rows(J, 0);
    add(1, J, 0, 1, ev(4'd9, SB_PC, 2'b00, 2'b00, 0, 2'b00, 2'b10, 1, 0));
    // ADDI, ORI
    fetch_decode_rows(ADDI, 0);
    add(1, ADDI, 0, 1, ev(4'd10, SB_NONE, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0));
    add(1, ADDI, 0, 1, ev(4'd11, SB_RW,   2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0));
    fetch_decode_rows(ORI, 0);
    add(1, ORI, 0, 1, ev(4'd10, SB_NONE, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0));
    add(1, ORI, 0, 1, ev(4'd11, SB_RW,   2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0));
    // Illegal opcode
    add(1, BAD, 0, 1, ev(4'd0, SB_FRDY, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    add(1, BAD, 0, 1, ev(4'd1,  SB_NONE, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0));
    add(1, BAD, 0, 1, ev(4'd15, SB_NONE, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    add(1, LW,  0, 1, ev(4'd15, SB_NONE, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    add(1, LW,  0, 1, ev(4'd15, SB_NONE, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
`else
    add(1, BAD, 0, 1, ev(4'd1, SB_NONE, 2'b00, 2'b00, 0, 2'b11, 2'b00, 1, 0));
    add(1, LW,  0, 0, ev(4'd0, SB_FWAIT, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0));
`endif

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; opcode = vecs[i].op; funct = vecs[i].fn; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d", i), 32'(act), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end

    // Reset clears whatever state the table left behind (HALT when trapping)
    rst_n = 1'b0; mem_ready = 1'b1; opcode = LW; funct = 6'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_mem_read", 32'(mem_read), 32'd1);
    check("post_reset_illegal", 32'(illegal), 32'd0);
    check("post_reset_done", 32'(instr_done), 32'd0);

    // Reset while in MEM_READ aborts the LW
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state_memread", 32'(state), 32'd3);
    check("abort_mem_read_gated", 32'(mem_read), 32'd0);
    check("abort_reg_write", 32'(reg_write), 32'd0);
    check("abort_done", 32'(instr_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("abort_next_state", 32'(state), 32'd0);
    check("abort_next_reg_write", 32'(reg_write), 32'd0);
    check("abort_next_done", 32'(instr_done), 32'd0);
    check("abort_next_ir_write", 32'(ir_write), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_wait_hold_state", 32'(state), 32'd0);
    check("fetch_wait_hold_mem_read", 32'(mem_read), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS32 main controller. Sequences one instruction at a time through fetch, decode, execute, memory and writeback states. Drives the PC, IR, memory, register-file and ALU-operand mux selects around the shared ALU, whose operation comes from the ALU decoder. Stalls on a single memory-ready handshake shared by instruction and data accesses.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  Clock. All state changes on the rising edge.
- i_rst_n  in  1  Reset. Synchronous, active-low.
- i_opcode  in  6  Opcode field, taken from the IR. Valid from DECODE onward.
- i_funct  in  6  Funct field, taken from the IR.
- i_mem_ready  in  1  Memory has completed the current read or write this cycle.
- o_pc_write  out  1  Unconditional PC load.
- o_pc_write_cond  out  1  PC load qualified by the datapath branch flag.
- o_iord  out  1  Memory address select: 0 = PC, 1 = ALUOut.
- o_mem_read  out  1  Memory read request.
- o_mem_write  out  1  Memory write request.
- o_ir_write  out  1  IR load.
- o_reg_write  out  1  Register-file write.
- o_reg_dst  out  2  Destination register: 00 = rt, 01 = rd, 10 = $31.
- o_mem_to_reg  out  2  Writeback source: 00 = ALUOut, 01 = MDR, 10 = PC.
- o_alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A register.
- o_alu_src_b  out  2  ALU B operand: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- o_pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A register (rs).
- o_instr_done  out  1  One-cycle pulse in the final cycle of each instruction.
- o_state  out  4  Current state encoding, for debug.
- o_illegal  out  1  Illegal-instruction flag (see Configuration).

## Operation
- Moore FSM: 4-bit state register. Outputs are decoded from the state and i_mem_ready.
- Any strobe not listed for a state is 0. Any select not listed for a state is 00/0.
- State encodings and transitions:
  - FETCH (0): mem_read=1, alu_src_b=01.
    - If i_mem_ready: ir_write=1, pc_write=1, next state DECODE.
    - Else: stay in FETCH.
  - DECODE (1): alu_src_b=11 (branch target into ALUOut). Next state by opcode:
    - 100011 / 101011 (LW/SW) → MEM_ADDR.
    - 000000 with funct 001000 (JR) → JR.
    - 000000 otherwise → R_EXEC.
    - 000100 / 000101 (BEQ/BNE) → BRANCH.
    - 001000, 001010, 001011, 001100, 001101, 001110, 001111 → I_EXEC.
    - 000010 → JUMP.
    - 000011 → JAL.
    - Any other opcode → ILLEGAL handling.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10. Next: LW → MEM_READ, SW → MEM_WRITE.
  - MEM_READ (3): mem_read=1, iord=1. Advance to MEM_WB only on i_mem_ready.
  - MEM_WB (4): reg_write=1, reg_dst=00, mem_to_reg=01, done=1. Next: FETCH.
  - MEM_WRITE (5): mem_write=1, iord=1. On i_mem_ready: done=1, next FETCH.
  - R_EXEC (6): alu_src_a=1, alu_src_b=00. Next: R_WB.
  - R_WB (7): reg_write=1, reg_dst=01, done=1. Next: FETCH.
  - BRANCH (8): alu_src_a=1, pc_write_cond=1, pc_source=01, done=1. Next: FETCH.
  - JUMP (9): pc_write=1, pc_source=10, done=1. Next: FETCH.
  - I_EXEC (10): alu_src_a=1, alu_src_b=10. Next: I_WB.
  - I_WB (11): reg_write=1, reg_dst=00, done=1. Next: FETCH.
  - JAL (12): pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, done=1. Next: FETCH.
  - JR (13): pc_write=1, pc_source=11, done=1. Next: FETCH.
  - HALT (15): all strobes 0, o_illegal=1. Stays in HALT until reset.
- Encoding 14 is unreachable. If it is ever entered, the next state is FETCH.
- Branch sense (BEQ vs BNE) is resolved in the datapath from the ALU decoder's control. This block only qualifies the PC load.

## Timing
- Reset: while i_rst_n=0 at a clock edge, the state is forced to FETCH.
  - During any cycle with i_rst_n=0, all write strobes and request outputs are forced to 0.
  - Outputs after reset release: o_state=0, o_illegal=0, o_instr_done=0.
- Reset mid-instruction aborts the instruction. No done pulse is issued. The next cycle is FETCH.
- Latency with zero wait states:
  - LW: 5 cycles.
  - SW, R-type, I-type: 4 cycles.
  - BEQ, BNE, J, JAL, JR: 3 cycles.
- Each cycle with i_mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
  - Request outputs stay asserted and stable while waiting.
  - Strobes gated by i_mem_ready (ir_write, pc_write in FETCH; done in MEM_WRITE) fire only in the ready cycle.
- i_mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- o_instr_done is high for exactly one cycle per retired instruction, and 0 in HALT.

## Configuration
- MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE moves the FSM to HALT. o_illegal=1 from the next cycle until reset.
- Macro undefined: an unrecognised opcode goes DECODE → FETCH with done=1 in DECODE (treated as a NOP). HALT is not implemented and o_illegal is tied to 0.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with i_mem_ready=1 → all strobes 0 during reset; o_state=0 and o_mem_read=1 in the first cycle after release.
- LW, opcode 100011, ready always 1 → states 0,1,2,3,4. Cycle 5 has reg_write=1, mem_to_reg=01, done=1. Next state is FETCH.
- SW, opcode 101011, with 3 cycles of i_mem_ready=0 in MEM_WRITE → mem_write and iord held high for 4 cycles, a single done pulse, total 7 cycles.
- R-type ADD (funct 100000), then JR (funct 001000), then JAL (000011):
  - ADD: 4 cycles, reg_dst=01 in R_WB.
  - JR: 3 cycles, pc_source=11.
  - JAL: 3 cycles, reg_dst=10, mem_to_reg=10, pc_write=1.
- BEQ (000100) → DECODE has alu_src_b=11. BRANCH has pc_write_cond=1, pc_source=01, pc_write=0.
- Opcode 111111:
  - With the macro defined: HALT, o_illegal=1, no further memory requests until reset.
  - Without the macro: back in FETCH after 2 cycles.
- Assert i_rst_n=0 while the FSM is in MEM_READ → no reg_write, no done pulse, FETCH on the next cycle.
